// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings and the next-state graph.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2DR = 4'h0,
    EX1DR = 4'h1,
    SHDR  = 4'h2,
    PDR   = 4'h3,
    SELIR = 4'h4,
    UDR   = 4'h5,
    CAPDR = 4'h6,
    SELDR = 4'h7,
    EX2IR = 4'h8,
    EX1IR = 4'h9,
    SHIR  = 4'hA,
    PIR   = 4'hB,
    RTI   = 4'hC,
    UIR   = 4'hD,
    CAPIR = 4'hE,
    TLR   = 4'hF
  } tap_state_e;

  // Standard 16-state TAP controller transition on a TCK rising edge.
  function automatic tap_state_e next_tap(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    unique case (state)
      TLR:     nxt = tms ? TLR   : RTI;
      RTI:     nxt = tms ? SELDR : RTI;
      SELDR:   nxt = tms ? SELIR : CAPDR;
      CAPDR:   nxt = tms ? EX1DR : SHDR;
      SHDR:    nxt = tms ? EX1DR : SHDR;
      EX1DR:   nxt = tms ? UDR   : PDR;
      PDR:     nxt = tms ? EX2DR : PDR;
      EX2DR:   nxt = tms ? UDR   : SHDR;
      UDR:     nxt = tms ? SELDR : RTI;
      SELIR:   nxt = tms ? TLR   : CAPIR;
      CAPIR:   nxt = tms ? EX1IR : SHIR;
      SHIR:    nxt = tms ? EX1IR : SHIR;
      EX1IR:   nxt = tms ? UIR   : PIR;
      PIR:     nxt = tms ? EX2IR : PIR;
      EX2IR:   nxt = tms ? UIR   : SHIR;
      UIR:     nxt = tms ? SELDR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Shadow TAP controller for one target chain; advances only when enabled.
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tms,
  output logic [3:0] state
);

  tap_state_e r_state;
  tap_state_e w_next;

  // State register: every chain starts in Test-Logic-Reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TLR;
    else        r_state <= w_next;
  end

  // Next state: follow the TAP graph on enabled TCK rises, hold otherwise.
  always_comb begin
    w_next = r_state;
    if (en) w_next = next_tap(r_state, tms);
  end

  // Output: expose the raw 4-bit encoding.
  always_comb begin
    state = r_state;
  end

endmodule

// File: rtl/jtag_chain_bridge.sv
// Routes a bitbang JTAG host onto one of CHAINS target chains, tracking each
// chain's TAP state so that chain switches only happen in TLR/RTI with TCK low.
module jtag_chain_bridge
  import jtag_pkg::*;
#(
  parameter int unsigned CHAINS      = 2,
  parameter int unsigned SEL_W       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH_W   = 22
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              host_tck,
  input  logic              host_tms,
  input  logic              host_tdi,
  output logic              host_tdo,
  input  logic [SEL_W-1:0]  sel_req,
  output logic [CHAINS-1:0] tgt_tck,
  output logic [CHAINS-1:0] tgt_tms,
  output logic [CHAINS-1:0] tgt_tdi,
  input  logic [CHAINS-1:0] tgt_tdo,
  output logic [SEL_W-1:0]  sel_active,
  output logic              sel_pending,
  output logic [3:0]        tap_state,
  output logic              activity
);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic [SYNC_STAGES-1:0] r_tdi_sync;
  logic [SYNC_STAGES-1:0] r_tdo_sync [CHAINS];
  logic                   w_tck_s;
  logic                   w_tms_s;
  logic                   w_tdi_s;
  logic [CHAINS-1:0]      w_tdo_s;
  logic                   r_tck_d;
  logic                   w_rise;
  logic                   w_fall;
  logic [3:0]             w_tap_state [CHAINS];
  logic [3:0]             w_active_tap;
  logic                   w_req_valid;
  logic                   w_req_diff;
  logic                   w_safe;
  logic                   w_switch;
  logic [SEL_W-1:0]       r_sel_active;
  logic                   r_sel_pending;
  logic [CHAINS-1:0]      r_tgt_tck;
  logic [CHAINS-1:0]      r_tgt_tms;
  logic [CHAINS-1:0]      r_tgt_tdi;
  logic                   r_host_tdo;
  logic [STRETCH_W-1:0]   r_stretch;

  // Reset: asserts asynchronously, releases synchronously to clk_25mhz.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Host input synchronisers, reset to an idle bus (TCK low, TMS/TDI high).
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '1;
      r_tdi_sync <= '1;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], host_tck};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], host_tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], host_tdi};
    end
  end
  assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
  assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < CHAINS; g++) begin : g_chain
    // Target TDO synchroniser for this chain, idles high.
    always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
      if (!w_rst_n) r_tdo_sync[g] <= '1;
      else          r_tdo_sync[g] <= {r_tdo_sync[g][SYNC_STAGES-2:0], tgt_tdo[g]};
    end
    assign w_tdo_s[g] = r_tdo_sync[g][SYNC_STAGES-1];

    jtag_tap_tracker u_tracker (
      .clk   (clk_25mhz),
      .rst_n (w_rst_n),
      .en    (w_rise & (r_sel_active == SEL_W'(g))),
      .tms   (w_tms_s),
      .state (w_tap_state[g])
    );
  end

  // TCK edge detector on the synchronised clock.
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) r_tck_d <= 1'b0;
    else          r_tck_d <= w_tck_s;
  end
  assign w_rise = w_tck_s & ~r_tck_d;
  assign w_fall = ~w_tck_s & r_tck_d;

  assign w_active_tap = w_tap_state[r_sel_active];

  // Out-of-range requests are treated as "no change" so they never pend.
  assign w_req_valid = ({1'b0, sel_req} < (SEL_W + 1)'(CHAINS));
  assign w_req_diff  = w_req_valid && (sel_req != r_sel_active);
  assign w_safe      = ((w_active_tap == 4'(TLR)) || (w_active_tap == 4'(RTI)))
                       && !w_tck_s && !w_rise;
  assign w_switch    = w_req_diff && w_safe;

  // Chain selection: take the latest request once the active TAP is parked.
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sel_active  <= '0;
      r_sel_pending <= 1'b0;
    end else begin
      if (w_switch) r_sel_active <= sel_req;
      r_sel_pending <= w_req_diff && !w_safe;
    end
  end

  // Forward/return routing: active chain follows the host, others park idle.
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tgt_tck  <= '0;
      r_tgt_tms  <= '1;
      r_tgt_tdi  <= '1;
      r_host_tdo <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < CHAINS; i++) begin
        if (r_sel_active == SEL_W'(i)) begin
          r_tgt_tck[i] <= w_tck_s;
          r_tgt_tms[i] <= w_tms_s;
          r_tgt_tdi[i] <= w_tdi_s;
        end else begin
          r_tgt_tck[i] <= 1'b0;
          r_tgt_tms[i] <= 1'b1;
          r_tgt_tdi[i] <= 1'b1;
        end
      end
      r_host_tdo <= w_tdo_s[r_sel_active];
    end
  end

  // Activity stretcher: reload on any TCK edge, count down and saturate at 0.
  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n)                r_stretch <= '0;
    else if (w_rise || w_fall)   r_stretch <= '1;
    else if (r_stretch != '0)    r_stretch <= r_stretch - STRETCH_W'(1);
  end

  assign tgt_tck     = r_tgt_tck;
  assign tgt_tms     = r_tgt_tms;
  assign tgt_tdi     = r_tgt_tdi;
  assign host_tdo    = r_host_tdo;
  assign sel_active  = r_sel_active;
  assign sel_pending = r_sel_pending;
  assign tap_state   = w_active_tap;
  assign activity    = (r_stretch != '0);

endmodule

// File: tb/tb_jtag_chain_bridge.sv
// Directed bench for jtag_chain_bridge using three chains and a short stretcher.
module tb_jtag_chain_bridge;

  logic       clk;
  logic       rst_n;
  logic       host_tck, host_tms, host_tdi, host_tdo;
  logic [1:0] sel_req;
  logic [2:0] tgt_tck, tgt_tms, tgt_tdi, tgt_tdo;
  logic [1:0] sel_active;
  logic       sel_pending;
  logic [3:0] tap_state;
  logic       activity;

  int n_checks = 0;
  int n_pass   = 0;

  jtag_chain_bridge #(
    .CHAINS      (3),
    .SEL_W       (2),
    .SYNC_STAGES (2),
    .STRETCH_W   (4)
  ) dut (
    .clk_25mhz   (clk),
    .rst_n       (rst_n),
    .host_tck    (host_tck),
    .host_tms    (host_tms),
    .host_tdi    (host_tdi),
    .host_tdo    (host_tdo),
    .sel_req     (sel_req),
    .tgt_tck     (tgt_tck),
    .tgt_tms     (tgt_tms),
    .tgt_tdi     (tgt_tdi),
    .tgt_tdo     (tgt_tdo),
    .sel_active  (sel_active),
    .sel_pending (sel_pending),
    .tap_state   (tap_state),
    .activity    (activity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tck_pulse(input logic tms);
    host_tms = tms;
    tick(6);
    host_tck = 1'b1;
    tick(6);
    host_tck = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    tgt_tdo  = 3'b000;
    host_tdi = 1'b0;
    host_tck = 1'b1;
    tick(6);
    rst_n = 1'b0;
    #1;
    n_checks++; if (tgt_tck !== 3'b000) $display("FAIL rst_tck got %b exp 000", tgt_tck); else n_pass++;
    n_checks++; if (tgt_tms !== 3'b111) $display("FAIL rst_tms got %b exp 111", tgt_tms); else n_pass++;
    n_checks++; if (tgt_tdi !== 3'b111) $display("FAIL rst_tdi got %b exp 111", tgt_tdi); else n_pass++;
    n_checks++; if (host_tdo !== 1'b1) $display("FAIL rst_tdo got %b exp 1", host_tdo); else n_pass++;
    n_checks++; if (tap_state !== 4'hF) $display("FAIL rst_tap got %h exp F", tap_state); else n_pass++;
    n_checks++; if (sel_active !== 2'd0) $display("FAIL rst_sel got %0d exp 0", sel_active); else n_pass++;
    n_checks++; if (sel_pending !== 1'b0) $display("FAIL rst_pend got %b exp 0", sel_pending); else n_pass++;
    n_checks++; if (activity !== 1'b0) $display("FAIL rst_act got %b exp 0", activity); else n_pass++;
    host_tck = 1'b0;
    host_tdi = 1'b1;
    tgt_tdo  = 3'b111;
    tick(2);
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_latency;
    host_tck = 1'b1;
    tgt_tdo  = 3'b110;
    tick(2);
    n_checks++; if (tgt_tck !== 3'b000) $display("FAIL lat_tck_c2 got %b exp 000", tgt_tck); else n_pass++;
    n_checks++; if (host_tdo !== 1'b1) $display("FAIL lat_tdo_c2 got %b exp 1", host_tdo); else n_pass++;
    tick(1);
    n_checks++; if (tgt_tck !== 3'b001) $display("FAIL lat_tck_c3 got %b exp 001", tgt_tck); else n_pass++;
    n_checks++; if (host_tdo !== 1'b0) $display("FAIL lat_tdo_c3 got %b exp 0", host_tdo); else n_pass++;
    tgt_tdo  = 3'b111;
    host_tck = 1'b0;
    tick(6);
    n_checks++; if (tap_state !== 4'hF) $display("FAIL lat_tap got %h exp F", tap_state); else n_pass++;
  endtask

  task automatic test_tap_walk;
    logic       tms_v [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_v [7] = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h5, 4'hC};
    for (int i = 0; i < 7; i++) begin
      tck_pulse(tms_v[i]);
      n_checks++;
      if (tap_state !== exp_v[i])
        $display("FAIL walk_%0d got %h exp %h", i, tap_state, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_deferred_switch;
    tck_pulse(1'b1);
    tck_pulse(1'b0);
    tck_pulse(1'b0);
    n_checks++; if (tap_state !== 4'h2) $display("FAIL def_shdr got %h exp 2", tap_state); else n_pass++;
    sel_req = 2'd1;
    tick(4);
    n_checks++; if (sel_pending !== 1'b1) $display("FAIL def_pend got %b exp 1", sel_pending); else n_pass++;
    n_checks++; if (sel_active !== 2'd0) $display("FAIL def_hold got %0d exp 0", sel_active); else n_pass++;
    tck_pulse(1'b1);
    tck_pulse(1'b1);
    n_checks++; if (sel_active !== 2'd0) $display("FAIL def_udr_hold got %0d exp 0", sel_active); else n_pass++;
    tck_pulse(1'b0);
    n_checks++; if (sel_active !== 2'd1) $display("FAIL def_sel got %0d exp 1", sel_active); else n_pass++;
    n_checks++; if (sel_pending !== 1'b0) $display("FAIL def_pclr got %b exp 0", sel_pending); else n_pass++;
    n_checks++; if (tap_state !== 4'hF) $display("FAIL def_tap got %h exp F", tap_state); else n_pass++;
    n_checks++; if (tgt_tck !== 3'b000) $display("FAIL def_tck got %b exp 000", tgt_tck); else n_pass++;
    n_checks++; if (tgt_tms !== 3'b101) $display("FAIL def_tms got %b exp 101", tgt_tms); else n_pass++;
    tgt_tdo = 3'b101;
    tick(4);
    n_checks++; if (host_tdo !== 1'b0) $display("FAIL def_tdo got %b exp 0", host_tdo); else n_pass++;
    tgt_tdo = 3'b111;
    tick(4);
  endtask

  task automatic test_tlr_and_invalid;
    logic [3:0] exp_v [5] = '{4'h9, 4'hD, 4'h7, 4'h4, 4'hF};
    tck_pulse(1'b0);
    tck_pulse(1'b1);
    tck_pulse(1'b1);
    tck_pulse(1'b0);
    tck_pulse(1'b0);
    n_checks++; if (tap_state !== 4'hA) $display("FAIL tlr_shir got %h exp A", tap_state); else n_pass++;
    sel_req = 2'd3;
    tick(4);
    n_checks++; if (sel_pending !== 1'b0) $display("FAIL inv_pend got %b exp 0", sel_pending); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tck_pulse(1'b1);
      n_checks++;
      if (tap_state !== exp_v[i])
        $display("FAIL tlr_%0d got %h exp %h", i, tap_state, exp_v[i]);
      else n_pass++;
    end
    tick(4);
    n_checks++; if (sel_active !== 2'd1) $display("FAIL inv_sel got %0d exp 1", sel_active); else n_pass++;
    n_checks++; if (sel_pending !== 1'b0) $display("FAIL inv_pend2 got %b exp 0", sel_pending); else n_pass++;
    sel_req = 2'd0;
    tick(6);
    n_checks++; if (sel_active !== 2'd0) $display("FAIL back_sel got %0d exp 0", sel_active); else n_pass++;
    n_checks++; if (tap_state !== 4'hC) $display("FAIL back_tap got %h exp C", tap_state); else n_pass++;
  endtask

  task automatic test_activity;
    host_tms = 1'b1;
    tick(20);
    n_checks++; if (activity !== 1'b0) $display("FAIL act_idle got %b exp 0", activity); else n_pass++;
    host_tck = 1'b1;
    tick(17);
    n_checks++; if (activity !== 1'b1) $display("FAIL act_last got %b exp 1", activity); else n_pass++;
    tick(1);
    n_checks++; if (activity !== 1'b0) $display("FAIL act_expire got %b exp 0", activity); else n_pass++;
    host_tck = 1'b0;
    tick(10);
    host_tck = 1'b1;
    tick(17);
    n_checks++; if (activity !== 1'b1) $display("FAIL act_reload got %b exp 1", activity); else n_pass++;
    tick(1);
    n_checks++; if (activity !== 1'b0) $display("FAIL act_reexp got %b exp 0", activity); else n_pass++;
    host_tck = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n    = 1'b0;
    host_tck = 1'b0;
    host_tms = 1'b1;
    host_tdi = 1'b1;
    tgt_tdo  = 3'b111;
    sel_req  = 2'd0;
    test_reset();
    test_latency();
    test_tap_walk();
    test_deferred_switch();
    test_tlr_and_invalid();
    test_activity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
